trace_tx: RTL

//  Hardware commit-trace transmitter. Captures one record per retired instruction
//  (pc, inst, alu_out) from cpu_top, buffers records in a small FIFO, and streams

---
 rtl/trace_tx_if.sv | 26 ++
 rtl/trace_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/trace_tx_if.sv
// Commit-trace bus: per-instruction capture fields in, framed byte stream out.
// The slave modport is the transmitter's view; the master modport is the view of
// whoever drives retirements and consumes bytes.
interface trace_tx_if;
   logic        trace_valid;
   logic [31:0] trace_pc;
   logic [31:0] trace_inst;
   logic [31:0] trace_alu;
   logic [31:0] trace_rs1;
   logic [31:0] trace_rs2;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   modport slave (
      input  trace_valid, trace_pc, trace_inst, trace_alu, trace_rs1, trace_rs2,
      input  tx_ready,
      output tx_valid, tx_data
   );

   modport master (
      output trace_valid, trace_pc, trace_inst, trace_alu, trace_rs1, trace_rs2,
      output tx_ready,
      input  tx_valid, tx_data
   );
endinterface

// File: rtl/trace_tx.sv
// Commit-trace transmitter: buffers one record per retired instruction in a small
// FIFO and streams each record as a framed little-endian byte sequence.
// Frame: A5, seq, pc[4], inst[4], alu[4] (14 bytes).
// Optional macro TRACE_RS_DATA_EN: appends rs1[4], rs2[4] (22 bytes) and stores them.
module trace_tx #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DROP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   trace_tx_if.slave         io,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              busy
);

`ifdef TRACE_RS_DATA_EN
   localparam int unsigned NBYTES = 22;
`else
   localparam int unsigned NBYTES = 14;
`endif
   localparam int unsigned FRAME_W = NBYTES * 8;
   localparam int unsigned IDX_W   = $clog2(NBYTES);
   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned LVL_W   = PTR_W + 1;

   // One stored record; field order makes {rec, sync} the little-endian frame image.
   typedef struct packed {
`ifdef TRACE_RS_DATA_EN
      logic [31:0] rs2;
      logic [31:0] rs1;
`endif
      logic [31:0] alu;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [7:0]  seq;
   } rec_t;

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state;
   logic [IDX_W-1:0] byte_idx;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level;
   logic [7:0]       seq;
   rec_t             mem [DEPTH];

   rec_t               wr_rec;
   logic [FRAME_W-1:0] head_frame;
   logic               hs;
   logic               last_byte;
   logic               pop;
   logic               full;
   logic               push;
   logic               drop;

`ifndef TRACE_RS_DATA_EN
   // rs1/rs2 carry no storage in the short frame.
   logic unused_rs;
   assign unused_rs = ^{io.trace_rs1, io.trace_rs2};
`endif

   // Record assembled from the retiring instruction, tagged with the current seq.
   always_comb begin
      wr_rec      = '0;
      wr_rec.seq  = seq;
      wr_rec.pc   = io.trace_pc;
      wr_rec.inst = io.trace_inst;
      wr_rec.alu  = io.trace_alu;
`ifdef TRACE_RS_DATA_EN
      wr_rec.rs1  = io.trace_rs1;
      wr_rec.rs2  = io.trace_rs2;
`endif
   end

   // Handshake, pop and accept/drop decisions; a full FIFO still accepts on the pop edge.
   always_comb begin
      hs        = (state == SEND) && io.tx_ready;
      last_byte = (byte_idx == IDX_W'(NBYTES - 1));
      pop       = hs && last_byte;
      full      = (level == LVL_W'(DEPTH));
      push      = io.trace_valid && (!full || pop);
      drop      = io.trace_valid && !push;
   end

   // Byte mux from the FIFO head; forced to zero while nothing is offered.
   always_comb begin
      head_frame = {mem[rd_ptr], 8'hA5};
      io.tx_data = 8'h00;
      if (state == SEND) begin
         io.tx_data = 8'(head_frame >> {byte_idx, 3'b000});
      end
   end

   assign io.tx_valid = (state == SEND);
   assign busy        = (level != '0);

   // Record storage; contents need no reset since pointers and level define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_rec;
      end
   end

   // FIFO bookkeeping, sequence/drop counters and the IDLE/SEND serializer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         byte_idx <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         seq      <= '0;
         drop_cnt <= '0;
      end else begin
         if (io.trace_valid) begin
            seq <= seq + 8'd1;
         end
         if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase

         case (state)
            IDLE: begin
               byte_idx <= '0;
               if (push) begin
                  state <= SEND;
               end
            end
            SEND: begin
               if (hs) begin
                  if (last_byte) begin
                     byte_idx <= '0;
                     if ((level == LVL_W'(1)) && !push) begin
                        state <= IDLE;
                     end
                  end else begin
                     byte_idx <= byte_idx + IDX_W'(1);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               byte_idx <= '0;
            end
         endcase
      end
   end

endmodule
